// File: rtl/mprj_io_seq_checker_if.sv
// Control/status bundle for the GPIO sequence checker: table loading,
// run control and the status/observation outputs.
interface mprj_io_seq_checker_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int SW = $clog2(DEPTH + 1);

  logic             exp_wr;
  logic [WIDTH-1:0] exp_data;
  logic             start;
  logic             clear;
  logic             busy;
  logic             pass;
  logic             fail;
  logic             overflow;
  logic [SW-1:0]    step_idx;
  logic             match;
  logic [WIDTH-1:0] sample;

  modport master (
    output exp_wr, exp_data, start, clear,
    input  busy, pass, fail, overflow, step_idx, match, sample
  );

  modport slave (
    input  exp_wr, exp_data, start, clear,
    output busy, pass, fail, overflow, step_idx, match, sample
  );
endinterface

// File: rtl/mprj_io_seq_checker.sv
// Sequence checker for the user-project GPIO outputs. The pins are
// synchronized, then compared in order against a programmed list of
// expected values; each entry must be seen stable for STABLE_CYCLES
// consecutive samples before the next entry is awaited. A run ends in
// pass (all entries seen) or fail (cycle budget exhausted).
module mprj_io_seq_checker #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 25000
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic [WIDTH-1:0]       io_in,
  mprj_io_seq_checker_if.slave   bus
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_PASS = 2'd2,
    DONE_FAIL = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sync_p0, sync_p1;
  logic [WIDTH-1:0] exp_tab [DEPTH];
  logic [SW-1:0]    count, count_nxt;
  logic [SW-1:0]    step_idx, step_idx_nxt;
  logic [CW-1:0]    stable_cnt, stable_nxt;
  logic [31:0]      tmo_cnt, tmo_nxt;
  logic             pass_q, pass_nxt;
  logic             fail_q, fail_nxt;
  logic             ovf_q, ovf_nxt;
  logic             wr_en;
  logic [WIDTH-1:0] cur_exp;
  logic             hit;
  logic             accept;

  // Two-flop synchronizer for the asynchronous pins; sync_p1 is the sample.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else if (bus.clear) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= io_in;
      sync_p1 <= sync_p0;
    end
  end

  // Select the entry currently awaited (mux avoids indexing past the table).
  always_comb begin
    cur_exp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (step_idx == SW'(i)) cur_exp = exp_tab[i];
    end
  end

  assign hit    = (sync_p1 == cur_exp);
  // The stable counter holds the number of matching samples already seen,
  // so acceptance happens in the cycle after the last required sample.
  assign accept = (state == RUN) && (stable_cnt == CW'(STABLE_CYCLES));

  // Next-state and next-register computation; clear overrides everything.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    step_idx_nxt = step_idx;
    stable_nxt   = stable_cnt;
    tmo_nxt      = tmo_cnt;
    pass_nxt     = pass_q;
    fail_nxt     = fail_q;
    ovf_nxt      = ovf_q;
    wr_en        = 1'b0;
    if (bus.clear) begin
      state_nxt    = IDLE;
      count_nxt    = '0;
      step_idx_nxt = '0;
      stable_nxt   = '0;
      tmo_nxt      = '0;
      pass_nxt     = 1'b0;
      fail_nxt     = 1'b0;
      ovf_nxt      = 1'b0;
    end else begin
      case (state)
        RUN: begin
          tmo_nxt = tmo_cnt + 32'd1;
          if (accept) begin
            stable_nxt   = '0;
            step_idx_nxt = step_idx + SW'(1);
          end else if (hit) begin
            stable_nxt = stable_cnt + CW'(1);
          end else begin
            stable_nxt = '0;
          end
          // A final acceptance beats a simultaneous timeout.
          if (accept && (step_idx == count - SW'(1))) begin
            state_nxt = DONE_PASS;
            pass_nxt  = 1'b1;
          end else if (tmo_cnt == 32'(TIMEOUT - 1)) begin
            state_nxt = DONE_FAIL;
            fail_nxt  = 1'b1;
          end
        end
        default: begin
          // Start takes priority over a same-cycle table write.
          if (bus.start) begin
            if (count == '0) begin
              state_nxt    = DONE_PASS;
              pass_nxt     = 1'b1;
              fail_nxt     = 1'b0;
              step_idx_nxt = '0;
            end else begin
              state_nxt    = RUN;
              step_idx_nxt = '0;
              stable_nxt   = '0;
              tmo_nxt      = '0;
              pass_nxt     = 1'b0;
              fail_nxt     = 1'b0;
            end
          end else if (bus.exp_wr) begin
            if (count == SW'(DEPTH)) begin
              ovf_nxt = 1'b1;
            end else begin
              wr_en     = 1'b1;
              count_nxt = count + SW'(1);
            end
          end
        end
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      count      <= '0;
      step_idx   <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      step_idx   <= step_idx_nxt;
      stable_cnt <= stable_nxt;
      tmo_cnt    <= tmo_nxt;
      pass_q     <= pass_nxt;
      fail_q     <= fail_nxt;
      ovf_q      <= ovf_nxt;
    end
  end

  // Expected-value table; contents need no reset since count gates them.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (count == SW'(i))) exp_tab[i] <= bus.exp_data;
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.overflow = ovf_q;
  assign bus.step_idx = step_idx;
  assign bus.match    = accept;
  assign bus.sample   = sync_p1;

endmodule

// File: tb/tb_mprj_io_seq_checker.sv
// Bench for the GPIO sequence checker: directed scenarios plus randomized
// runs, all compared every cycle against a queue-based reference model.
module tb_mprj_io_seq_checker;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 300;

  logic             clock;
  logic             resetb;
  logic [WIDTH-1:0] io_in;

  mprj_io_seq_checker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mprj_io_seq_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE_CYCLES(STABLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .resetb(resetb),
    .io_in (io_in),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_tab [$];
  logic [WIDTH-1:0] m_hist [$];
  bit               m_run, m_pass, m_fail, m_ovf, m_match;
  int               m_idx, m_elapsed;
  logic [WIDTH-1:0] m_s0, m_s1;

  int cyc = 0;
  int n_match = 0;
  int last_match_cyc = -1;
  int busy_fall_cyc = -1;
  bit prev_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the sample is the pin value two edges ago; an entry is accepted
  // once the last STABLE samples seen since the previous acceptance all equal it.
  task automatic model_edge();
    bit ok;
    if (!resetb || bus.clear) begin
      m_tab.delete(); m_hist.delete();
      m_run = 0; m_pass = 0; m_fail = 0; m_ovf = 0; m_match = 0;
      m_idx = 0; m_elapsed = 0; m_s0 = '0; m_s1 = '0;
      return;
    end
    if (m_run) begin
      m_elapsed++;
      if (m_match) begin
        m_idx++;
        m_hist.delete();
      end else begin
        m_hist.push_back(m_s1);
      end
      if (m_match && m_idx == m_tab.size()) begin
        m_run = 0; m_pass = 1;
      end else if (m_elapsed == TIMEOUT) begin
        m_run = 0; m_fail = 1;
      end
    end else if (bus.start) begin
      if (m_tab.size() == 0) begin
        m_pass = 1; m_fail = 0; m_idx = 0;
      end else begin
        m_run = 1; m_idx = 0; m_hist.delete(); m_elapsed = 0; m_pass = 0; m_fail = 0;
      end
    end else if (bus.exp_wr) begin
      if (m_tab.size() < DEPTH) m_tab.push_back(bus.exp_data);
      else m_ovf = 1;
    end
    m_s1 = m_s0;
    m_s0 = io_in;
    m_match = 0;
    if (m_run && m_hist.size() >= STABLE) begin
      ok = 1;
      for (int k = m_hist.size() - STABLE; k < m_hist.size(); k++)
        if (m_hist[k] != m_tab[m_idx]) ok = 0;
      m_match = ok;
    end
  endtask

  task automatic compare_all();
    chk("busy",     32'(bus.busy),     32'(m_run));
    chk("pass",     32'(bus.pass),     32'(m_pass));
    chk("fail",     32'(bus.fail),     32'(m_fail));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("step_idx", 32'(bus.step_idx), 32'(m_idx));
    chk("match",    32'(bus.match),    32'(m_match));
    chk("sample",   32'(bus.sample),   32'(m_s1));
  endtask

  // One clock: model update at the edge, DUT compare 1 ns later, return at negedge.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    compare_all();
    if (bus.match === 1'b1) begin
      n_match++;
      last_match_cyc = cyc;
    end
    if (prev_busy && bus.busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy = (bus.busy === 1'b1);
    @(negedge clock);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; cycle(); bus.clear = 1'b0;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    bus.exp_wr = 1'b1; bus.exp_data = v; cycle(); bus.exp_wr = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
  endtask

  task automatic hold(input logic [WIDTH-1:0] v, input int n);
    io_in = v;
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [WIDTH-1:0] seq1 [12];
  int base, apply_cyc, start_cyc, fail_cyc, nload;

  initial begin
    seq1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
    resetb = 1'b1; io_in = '0;
    bus.exp_wr = 1'b0; bus.exp_data = '0; bus.start = 1'b0; bus.clear = 1'b0;
    #2 resetb = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_step", 32'(bus.step_idx), 32'd0);
    chk("rst_sample", 32'(bus.sample), 32'd0);
    cycle(); cycle();
    resetb = 1'b1;
    cycle();

    // Twelve-entry sequence, each value held 10 cycles
    do_clear();
    foreach (seq1[i]) load(seq1[i]);
    pulse_start();
    base = n_match;
    foreach (seq1[i]) hold(seq1[i], 10);
    chk("t1_matches", 32'(n_match - base), 32'd12);
    chk("t1_step_idx", 32'(bus.step_idx), 32'd12);
    chk("t1_pass", 32'(bus.pass), 32'd1);
    chk("t1_fail", 32'(bus.fail), 32'd0);
    chk("t1_busy_fall", 32'(busy_fall_cyc - last_match_cyc), 32'd1);

    // Glitch of the second value must not be accepted
    do_clear();
    load(8'h01); load(8'h02);
    io_in = 8'h00;
    pulse_start();
    base = n_match;
    hold(8'h01, 10); hold(8'h02, 2); hold(8'h00, 1);
    chk("t2_glitch_ignored", 32'(n_match - base), 32'd1);
    apply_cyc = cyc;
    last_match_cyc = -1;
    hold(8'h02, 10);
    chk("t2_match_latency", 32'(last_match_cyc - apply_cyc), 32'(2 + STABLE));
    chk("t2_pass", 32'(bus.pass), 32'd1);

    // Timeout
    do_clear();
    load(8'h05);
    io_in = 8'h00;
    pulse_start();
    start_cyc = cyc;
    fail_cyc = -1;
    for (int i = 0; i < TIMEOUT + 20 && fail_cyc < 0; i++) begin
      cycle();
      if (bus.fail === 1'b1) fail_cyc = cyc;
    end
    chk("t3_fail_time", 32'(fail_cyc - start_cyc), 32'(TIMEOUT));
    chk("t3_pass", 32'(bus.pass), 32'd0);
    chk("t3_step_idx", 32'(bus.step_idx), 32'd0);

    // Empty-table start, then overflow on the 17th write
    do_clear();
    pulse_start();
    chk("t4_empty_pass", 32'(bus.pass), 32'd1);
    chk("t4_empty_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) load(8'(i + 1));
    chk("t4_no_ovf_yet", 32'(bus.overflow), 32'd0);
    load(8'hEE);
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) hold(8'(i + 1), 8);
    chk("t4_full_step", 32'(bus.step_idx), 32'd16);
    chk("t4_full_pass", 32'(bus.pass), 32'd1);

    // Asynchronous reset mid-run
    do_clear();
    load(8'h10); load(8'h20); load(8'h30); load(8'h40); load(8'h50);
    io_in = 8'h00;
    pulse_start();
    hold(8'h10, 8); hold(8'h20, 8); hold(8'h30, 8); hold(8'h77, 3);
    chk("t5_step_before", 32'(bus.step_idx), 32'd3);
    #2 resetb = 1'b0;
    #1;
    chk("t5_async_busy", 32'(bus.busy), 32'd0);
    chk("t5_async_step", 32'(bus.step_idx), 32'd0);
    chk("t5_async_sample", 32'(bus.sample), 32'd0);
    chk("t5_async_flags", 32'({bus.pass, bus.fail, bus.overflow, bus.match}), 32'd0);
    cycle();
    resetb = 1'b1;
    cycle();
    pulse_start();
    chk("t5_empty_pass", 32'(bus.pass), 32'd1);

    // Write and start together, then clear during a run
    do_clear();
    load(8'hAA); load(8'hBB);
    bus.exp_wr = 1'b1; bus.exp_data = 8'hCC; bus.start = 1'b1;
    cycle();
    bus.exp_wr = 1'b0; bus.start = 1'b0;
    chk("t6_busy", 32'(bus.busy), 32'd1);
    hold(8'hAA, 8); hold(8'hBB, 8);
    chk("t6_pass", 32'(bus.pass), 32'd1);
    chk("t6_step", 32'(bus.step_idx), 32'd2);
    pulse_start();
    hold(8'hAA, 8);
    do_clear();
    chk("t6_clr_busy", 32'(bus.busy), 32'd0);
    chk("t6_clr_step", 32'(bus.step_idx), 32'd0);
    pulse_start();
    chk("t6_clr_empty_pass", 32'(bus.pass), 32'd1);

    // Randomized runs with stray start/write/clear activity
    for (int r = 0; r < 8; r++) begin
      do_clear();
      nload = $urandom_range(1, (r == 3) ? DEPTH + 2 : 6);
      for (int i = 0; i < nload; i++) load(8'($urandom_range(0, 3)));
      pulse_start();
      for (int c = 0; c < 340; c++) begin
        if (m_run && $urandom_range(0, 99) < 70) io_in = m_tab[m_idx];
        else io_in = 8'($urandom_range(0, 3));
        bus.start    = ($urandom_range(0, 99) < 3);
        bus.exp_wr   = ($urandom_range(0, 99) < 5);
        bus.exp_data = 8'($urandom_range(0, 255));
        bus.clear    = ($urandom_range(0, 999) < 3);
        cycle();
      end
      bus.start = 1'b0; bus.exp_wr = 1'b0; bus.clear = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mprj_io_seq_checker.md
Name: mprj_io_seq_checker

Overview:
- Synthesizable sequence checker that consumes the user-project GPIO outputs (mprj_io[7:0]) downstream of the user-project I/O drivers.
- Verifies that the pins step through a programmed list of expected values, in order, each held stable for a minimum time.
- Reports pass, fail, or timeout status.
- Used both in gate-level benches and as an on-chip loopback monitor on the Caravel management side.

Parameters:
- WIDTH, 8: monitored bus width.
- DEPTH, 16: maximum entries in the expected-value table.
- STABLE_CYCLES, 4: consecutive synchronized samples required to accept a match; must be >= 1.
- TIMEOUT, 25000: RUN-state cycle budget before fail; 32-bit counter.

Ports:
- clock  in  1  core clock; all logic on rising edge.
- resetb  in  1  asynchronous active-low reset.
- io_in  in  WIDTH  monitored pins (mprj_io[WIDTH-1:0]); asynchronous to clock.
- exp_wr  in  1  write strobe; appends exp_data to the table.
- exp_data  in  WIDTH  expected value to append.
- start  in  1  single-cycle pulse; begins checking.
- clear  in  1  synchronous clear of the table, flags, and FSM.
- busy  out  1  high in RUN.
- pass  out  1  sticky pass flag.
- fail  out  1  sticky fail flag (timeout).
- overflow  out  1  sticky; a write was attempted with the table full.
- step_idx  out  clog2(DEPTH+1)  index of the entry currently awaited.
- match  out  1  one-cycle pulse when an entry is accepted.
- sample  out  WIDTH  current synchronized value of io_in.

Behaviour:
Reset and clear:
- resetb low: all outputs 0, state IDLE, entry count 0, all counters 0, sync flops 0.
- clear: same effect as reset, applied synchronously; highest priority in every state.

Input synchronization:
- io_in passes through a 2-flop synchronizer per bit.
- sample is the second flop.
- Latency from pin edge to sample is 2 cycles.

Table loading:
- exp_wr accepted only in IDLE, DONE_PASS, or DONE_FAIL with count < DEPTH: table[count] <= exp_data; count++.
- exp_wr with count == DEPTH: data dropped, overflow <= 1.
- exp_wr in RUN: ignored, no flag.
- exp_wr and start in the same cycle: start wins, write dropped.

FSM states: IDLE, RUN, DONE_PASS, DONE_FAIL.
- IDLE/DONE_*, start:
  - count == 0: go to DONE_PASS next cycle, pass <= 1.
  - otherwise: go to RUN; step_idx <= 0, stable counter <= 0, timeout counter <= 0, pass/fail <= 0.
- RUN, every cycle:
  - timeout counter increments.
  - If sample == table[step_idx], the stable counter increments; otherwise it resets to 0.
  - When the stable counter reaches STABLE_CYCLES (the sample has matched for STABLE_CYCLES consecutive cycles):
    - match pulses that cycle; step_idx++; stable counter <= 0.
    - The next entry's stability count starts on the following cycle.
  - If the accepted entry was the last (step_idx == count-1): go to DONE_PASS, pass <= 1.
  - Else if timeout counter == TIMEOUT-1: go to DONE_FAIL, fail <= 1.
  - Final match and timeout in the same cycle: pass wins.
- DONE_PASS/DONE_FAIL: hold flags and step_idx until start or clear; the table is retained, so start re-runs the same list.
- busy == (state == RUN).
- Matching is strictly in order. A value equal to a later entry is ignored. Repeated identical consecutive entries require the value to persist for STABLE_CYCLES after the previous acceptance.
- start during RUN: ignored.

Test Plan:
- Load 01,02,03,04,05,06,07,08,09,0A,FF,00; start; drive each value for 10 cycles -> 12 match pulses, step_idx reaches 12, pass=1, fail=0, busy falls the cycle after the last match.
- Load 01,02; drive 01 for 10 cycles, a 02 glitch for 2 cycles, 00, then 02 for 10 cycles -> glitch is not accepted; match for 02 occurs exactly 2+STABLE_CYCLES cycles after 02 is applied; pass=1.
- Load 05; start; hold io_in=00 -> fail=1 exactly TIMEOUT cycles after start; pass=0; step_idx=0.
- start with empty table -> pass=1 one cycle later, busy never asserts; then write 17 entries with DEPTH=16 -> count=16, overflow=1.
- resetb low mid-RUN at step_idx=3 -> all outputs 0 immediately (asynchronously); table empty after release; start yields an immediate pass.
- exp_wr and start in the same cycle with 2 entries loaded -> run uses 2 entries, new data not stored; clear in RUN -> IDLE next cycle with flags and count 0.
